// File: rtl/writeback_commit_unit_mc.sv
// rtl/writeback_commit_unit_mc.sv - multi-port writeback into a ROB with multi-lane in-order commit
module writeback_commit_unit_mc #(
    parameter int p_num_pipes      = 2,
    parameter int p_commit_width   = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [p_num_pipes-1:0]                     ex_val,
    output logic [p_num_pipes-1:0]                     ex_rdy,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]      ex_seq_num,
    input  logic [p_num_pipes*32-1:0]                  ex_pc,
    input  logic [p_num_pipes*5-1:0]                   ex_waddr,
    input  logic [p_num_pipes*32-1:0]                  ex_wdata,
    input  logic [p_num_pipes-1:0]                     ex_wen,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]    ex_preg,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]    ex_ppreg,
    output logic [p_num_pipes-1:0]                     complete_val,
    output logic [p_num_pipes*p_seq_num_bits-1:0]      complete_seq_num,
    output logic [p_num_pipes*5-1:0]                   complete_waddr,
    output logic [p_num_pipes*32-1:0]                  complete_wdata,
    output logic [p_num_pipes*p_phys_addr_bits-1:0]    complete_preg,
    output logic [p_num_pipes-1:0]                     complete_wen,
    input  logic                                       commit_stall,
    output logic [p_commit_width-1:0]                  commit_val,
    output logic [p_commit_width*p_seq_num_bits-1:0]   commit_seq_num,
    output logic [p_commit_width*32-1:0]               commit_pc,
    output logic [p_commit_width*5-1:0]                commit_waddr,
    output logic [p_commit_width*32-1:0]               commit_wdata,
    output logic [p_commit_width*p_phys_addr_bits-1:0] commit_ppreg,
    output logic [p_commit_width-1:0]                  commit_wen
);
    localparam int P = p_num_pipes;
    localparam int C = p_commit_width;
    localparam int S = p_seq_num_bits;
    localparam int R = p_phys_addr_bits;
    localparam int D = 2 ** S;

    logic [P-1:0] in_val;
    logic [S-1:0] in_seq   [P];
    logic [31:0]  in_pc    [P];
    logic [4:0]   in_waddr [P];
    logic [31:0]  in_wdata [P];
    logic [P-1:0] in_wen;
    logic [R-1:0] in_ppreg [P];

    logic [D-1:0] valid;
    logic [31:0]  rob_pc    [D];
    logic [4:0]   rob_waddr [D];
    logic [31:0]  rob_wdata [D];
    logic [D-1:0] rob_wen;
    logic [R-1:0] rob_ppreg [D];
    logic [S-1:0] head;

    logic [S-1:0] lane_idx [C];
    logic [D-1:0] retire_mask;
    logic [D-1:0] insert_mask;
    logic [S:0]   retire_cnt;
    logic         prefix;

    assign ex_rdy           = '1;
    assign complete_val     = ex_val;
    assign complete_seq_num = ex_seq_num;
    assign complete_waddr   = ex_waddr;
    assign complete_wdata   = ex_wdata;
    assign complete_preg    = ex_preg;

    for (genvar i = 0; i < P; i++) begin : g_cwen
        assign complete_wen[i] = ex_wen[i] & (ex_waddr[i*5 +: 5] != 5'd0);
    end

    // Index arithmetic relies on S-bit truncation to wrap modulo D.
    for (genvar k = 0; k < C; k++) begin : g_lane
        assign lane_idx[k] = head + S'(k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_val <= '0;
        end else begin
            in_val <= ex_val;
            for (int i = 0; i < P; i++) begin
                if (ex_val[i]) begin
                    in_seq[i]   <= ex_seq_num[i*S +: S];
                    in_pc[i]    <= ex_pc[i*32 +: 32];
                    in_waddr[i] <= ex_waddr[i*5 +: 5];
                    in_wdata[i] <= ex_wdata[i*32 +: 32];
                    in_wen[i]   <= complete_wen[i];
                    in_ppreg[i] <= ex_ppreg[i*R +: R];
                end
            end
        end
    end

    always_comb begin
        insert_mask = '0;
        for (int i = 0; i < P; i++) begin
            if (in_val[i]) insert_mask[in_seq[i]] = 1'b1;
        end
    end

    // Lanes form a prefix: the first non-ready slot blocks every younger lane.
    always_comb begin
        commit_val     = '0;
        commit_seq_num = '0;
        commit_pc      = '0;
        commit_waddr   = '0;
        commit_wdata   = '0;
        commit_ppreg   = '0;
        commit_wen     = '0;
        retire_mask    = '0;
        retire_cnt     = '0;
        prefix         = !commit_stall;
        for (int k = 0; k < C; k++) begin
            prefix = prefix & valid[lane_idx[k]];
            if (prefix) begin
                commit_val[k]             = 1'b1;
                commit_seq_num[k*S +: S]  = lane_idx[k];
                commit_pc[k*32 +: 32]     = rob_pc[lane_idx[k]];
                commit_waddr[k*5 +: 5]    = rob_waddr[lane_idx[k]];
                commit_wdata[k*32 +: 32]  = rob_wdata[lane_idx[k]];
                commit_ppreg[k*R +: R]    = rob_ppreg[lane_idx[k]];
                commit_wen[k]             = rob_wen[lane_idx[k]];
                retire_mask[lane_idx[k]]  = 1'b1;
                retire_cnt                = retire_cnt + (S+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
        end else begin
            valid <= (valid & ~retire_mask) | insert_mask;
            head  <= head + retire_cnt[S-1:0];
            for (int i = 0; i < P; i++) begin
                if (in_val[i]) begin
                    rob_pc[in_seq[i]]    <= in_pc[i];
                    rob_waddr[in_seq[i]] <= in_waddr[i];
                    rob_wdata[in_seq[i]] <= in_wdata[i];
                    rob_wen[in_seq[i]]   <= in_wen[i];
                    rob_ppreg[in_seq[i]] <= in_ppreg[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < P; i++) begin
                if (in_val[i]) assert (!valid[in_seq[i]]);
                for (int j = i + 1; j < P; j++) begin
                    assert (!(ex_val[i] && ex_val[j] &&
                              ex_seq_num[i*S +: S] == ex_seq_num[j*S +: S]));
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_commit_unit_mc.sv
// tb/tb_writeback_commit_unit_mc.sv - directed self-checking bench for writeback_commit_unit_mc
module tb_writeback_commit_unit_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ex_val;
    logic [1:0]  ex_rdy;
    logic [9:0]  ex_seq_num;
    logic [63:0] ex_pc;
    logic [9:0]  ex_waddr;
    logic [63:0] ex_wdata;
    logic [1:0]  ex_wen;
    logic [11:0] ex_preg;
    logic [11:0] ex_ppreg;
    logic [1:0]  complete_val;
    logic [9:0]  complete_seq_num;
    logic [9:0]  complete_waddr;
    logic [63:0] complete_wdata;
    logic [11:0] complete_preg;
    logic [1:0]  complete_wen;
    logic        commit_stall;
    logic [1:0]  commit_val;
    logic [9:0]  commit_seq_num;
    logic [63:0] commit_pc;
    logic [9:0]  commit_waddr;
    logic [63:0] commit_wdata;
    logic [11:0] commit_ppreg;
    logic [1:0]  commit_wen;

    int n_checks = 0;
    int n_fail   = 0;
    int retired;

    writeback_commit_unit_mc #(
        .p_num_pipes(2), .p_commit_width(2), .p_seq_num_bits(5), .p_phys_addr_bits(6)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_seq_num(ex_seq_num), .ex_pc(ex_pc),
        .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wen(ex_wen),
        .ex_preg(ex_preg), .ex_ppreg(ex_ppreg),
        .complete_val(complete_val), .complete_seq_num(complete_seq_num),
        .complete_waddr(complete_waddr), .complete_wdata(complete_wdata),
        .complete_preg(complete_preg), .complete_wen(complete_wen),
        .commit_stall(commit_stall), .commit_val(commit_val),
        .commit_seq_num(commit_seq_num), .commit_pc(commit_pc),
        .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
        .commit_ppreg(commit_ppreg), .commit_wen(commit_wen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        ex_val = '0;
        ex_wen = '0;
    endtask

    task automatic drive(input int p, input logic [4:0] seq, input logic [4:0] wa,
                         input logic [31:0] wd, input logic w);
        ex_val[p]             = 1'b1;
        ex_seq_num[p*5 +: 5]  = seq;
        ex_waddr[p*5 +: 5]    = wa;
        ex_wdata[p*32 +: 32]  = wd;
        ex_wen[p]             = w;
        ex_pc[p*32 +: 32]     = 32'h1000 + 32'(seq) * 4;
        ex_preg[p*6 +: 6]     = 6'(seq) + 6'd8;
        ex_ppreg[p*6 +: 6]    = 6'(seq) + 6'd16;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; commit_stall = 1'b0;
        ex_seq_num = '0; ex_pc = '0; ex_waddr = '0; ex_wdata = '0;
        ex_preg = '0; ex_ppreg = '0;
        idle();
        tick(); tick();
        rst = 1'b0;
        settle();
        check_eq("reset_commit_val", 64'(commit_val), 64'd0);
        check_eq("reset_ex_rdy", 64'(ex_rdy), 64'd3);

        // single completion: bypass in cyc1, commit in cyc3
        tick();
        drive(0, 5'd0, 5'd3, 32'hAAAA0001, 1'b1);
        settle();
        check_eq("bypass_val", 64'(complete_val), 64'd1);
        check_eq("bypass_wen", 64'(complete_wen), 64'd1);
        check_eq("bypass_wdata", 64'(complete_wdata[31:0]), 64'hAAAA0001);
        check_eq("bypass_preg", 64'(complete_preg[5:0]), 64'd8);
        check_eq("cyc1_no_commit", 64'(commit_val), 64'd0);
        tick(); idle(); settle();
        check_eq("cyc2_no_commit", 64'(commit_val), 64'd0);
        tick(); settle();
        check_eq("cyc3_commit_val", 64'(commit_val), 64'd1);
        check_eq("cyc3_pc", commit_pc, 64'h1000);
        check_eq("cyc3_wdata", commit_wdata, 64'hAAAA0001);
        check_eq("cyc3_waddr", 64'(commit_waddr), 64'd3);
        check_eq("cyc3_wen", 64'(commit_wen), 64'd1);
        check_eq("cyc3_ppreg", 64'(commit_ppreg), 64'd16);
        tick(); settle();
        check_eq("cyc4_drained", 64'(commit_val), 64'd0);

        // out of order across pipes, with an x0 destination on pipe1
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        drive(0, 5'd2, 5'd7, 32'h22, 1'b1);
        drive(1, 5'd1, 5'd0, 32'h11, 1'b1);
        settle();
        check_eq("ooo_bypass_val", 64'(complete_val), 64'd3);
        check_eq("x0_complete_wen", 64'(complete_wen), 64'd1);
        tick(); idle();
        drive(0, 5'd0, 5'd4, 32'habc, 1'b1);
        settle();
        check_eq("ooo_cyc2", 64'(commit_val), 64'd0);
        tick(); idle(); settle();
        check_eq("ooo_head_blocked", 64'(commit_val), 64'd0);
        tick(); settle();
        check_eq("ooo_cyc4_val", 64'(commit_val), 64'd3);
        check_eq("ooo_cyc4_seq", 64'(commit_seq_num), 64'h020);
        check_eq("ooo_cyc4_wdata", commit_wdata, {32'h11, 32'habc});
        check_eq("ooo_cyc4_waddr", 64'(commit_waddr), 64'h004);
        check_eq("x0_commit_wen", 64'(commit_wen), 64'd1);
        tick(); settle();
        check_eq("ooo_cyc5_val", 64'(commit_val), 64'd1);
        check_eq("ooo_cyc5_seq", 64'(commit_seq_num), 64'd2);
        check_eq("ooo_cyc5_pc", commit_pc, 64'h1008);

        // stream 30 entries to move head to 30, then wrap
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        retired = 0;
        for (int k = 0; k < 15; k++) begin
            drive(0, 5'(2*k), 5'd1, 32'(k), 1'b1);
            drive(1, 5'(2*k+1), 5'd2, 32'(k), 1'b1);
            settle();
            retired += $countones(commit_val);
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            settle();
            retired += $countones(commit_val);
            tick();
        end
        check_eq("stream_retired", 64'(retired), 64'd30);
        drive(0, 5'd30, 5'd5, 32'h30, 1'b1);
        drive(1, 5'd31, 5'd5, 32'h31, 1'b1);
        settle(); tick(); idle();
        drive(0, 5'd0, 5'd5, 32'h40, 1'b1);
        drive(1, 5'd1, 5'd5, 32'h41, 1'b1);
        settle(); tick(); idle(); settle();
        check_eq("wrap_a_val", 64'(commit_val), 64'd3);
        check_eq("wrap_a_seq", 64'(commit_seq_num), 64'h3FE);
        check_eq("wrap_a_wdata", commit_wdata, {32'h31, 32'h30});
        tick(); settle();
        check_eq("wrap_b_val", 64'(commit_val), 64'd3);
        check_eq("wrap_b_seq", 64'(commit_seq_num), 64'h020);
        check_eq("wrap_b_wdata", commit_wdata, {32'h41, 32'h40});
        tick(); settle();
        check_eq("wrap_drained", 64'(commit_val), 64'd0);

        // stall with ready entries; an insert during the stall still lands
        tick(); commit_stall = 1'b1;
        drive(0, 5'd2, 5'd6, 32'h52, 1'b1);
        drive(1, 5'd3, 5'd6, 32'h53, 1'b1);
        settle();
        tick(); idle(); settle();
        tick(); drive(0, 5'd4, 5'd6, 32'h54, 1'b1); settle();
        check_eq("stall_1", 64'(commit_val), 64'd0);
        tick(); idle(); settle();
        check_eq("stall_2", 64'(commit_val), 64'd0);
        tick(); settle();
        check_eq("stall_3", 64'(commit_val), 64'd0);
        tick(); commit_stall = 1'b0; settle();
        check_eq("release_val", 64'(commit_val), 64'd3);
        check_eq("release_seq", 64'(commit_seq_num), 64'h062);
        tick(); settle();
        check_eq("stall_insert_val", 64'(commit_val), 64'd1);
        check_eq("stall_insert_seq", 64'(commit_seq_num), 64'd4);

        // five valid entries (seq 5..9) held by a stall, then reset mid-flight
        tick(); commit_stall = 1'b1;
        drive(0, 5'd5, 5'd1, 32'h5, 1'b1); drive(1, 5'd6, 5'd1, 32'h6, 1'b1);
        settle(); tick(); idle();
        drive(0, 5'd7, 5'd1, 32'h7, 1'b1); drive(1, 5'd8, 5'd1, 32'h8, 1'b1);
        settle(); tick(); idle();
        drive(0, 5'd9, 5'd1, 32'h9, 1'b1);
        settle(); tick(); idle(); settle(); tick(); settle();
        tick(); rst = 1'b1; commit_stall = 1'b0;
        drive(0, 5'd0, 5'd1, 32'hDEAD, 1'b1);
        settle(); tick(); rst = 1'b0; idle();
        settle();
        check_eq("post_reset_val", 64'(commit_val), 64'd0);
        retired = 0;
        drive(1, 5'd0, 5'd9, 32'hC0, 1'b1); drive(0, 5'd1, 5'd9, 32'hC1, 1'b1);
        settle(); retired += $countones(commit_val); tick(); idle();
        drive(0, 5'd2, 5'd9, 32'hC2, 1'b1); drive(1, 5'd3, 5'd9, 32'hC3, 1'b1);
        settle(); retired += $countones(commit_val); tick(); idle();
        drive(0, 5'd4, 5'd9, 32'hC4, 1'b1);
        settle();
        check_eq("reuse_seq0_val", 64'(commit_val), 64'd3);
        check_eq("reuse_seq0_seq", 64'(commit_seq_num), 64'h020);
        check_eq("reuse_seq0_wdata", commit_wdata, {32'hC1, 32'hC0});
        retired += $countones(commit_val);
        tick(); idle();
        for (int k = 0; k < 8; k++) begin
            settle();
            retired += $countones(commit_val);
            tick();
        end
        check_eq("reset_dropped_entries", 64'(retired), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
